range_seq_monitor: RTL and testbench
====================================

# range_seq_monitor

Synthesizable multi-channel monitor for the SVA-style property `(a ##[MIN_DLY:MAX_DLY] b) |-> c`. Each channel tracks any number of overlapping antecedent attempts and evaluates the consequent when the delayed match occurs. It provides per-channel pass/fail pulses and saturating counters. It sits beside the assertion regression benches as a hardware reference model: its outputs are compared against simulator-evaluated concurrent assertions, and it also serves as an on-chip checker.

## Interface
- `NCHAN`, 4: number of independent channels.
- `MIN_DLY`, 1: lower bound of the delay window; legal range is MIN_DLY ≥ 1.
- `MAX_DLY`, 3: upper bound of the delay window; legal range is MIN_DLY ≤ MAX_DLY ≤ 32.
- `FIRST_MATCH`, 1: sets how attempts retire.
  - 1: an attempt retires on its first match.
  - 0: every `b` within the window produces an evaluation.
- `CNT_W`, 16: width of each counter.

- `clk`, in, 1: single clock; all sampling happens on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clear_i`, in, 1: synchronous clear of attempts and counters.
- `a_i`, in, NCHAN: antecedent, one bit per channel.
- `b_i`, in, NCHAN: delayed sequence term.
- `c_i`, in, NCHAN: consequent.
- `pass_o`, out, NCHAN: registered pulse; at least one attempt matched with `c`=1.
- `fail_o`, out, NCHAN: registered pulse; at least one attempt matched with `c`=0.
- `pass_cnt_o`, out, NCHAN*CNT_W: per-channel saturating pass count. Channel k occupies bits [k*CNT_W +: CNT_W].
- `fail_cnt_o`, out, NCHAN*CNT_W: per-channel saturating fail count, packed the same way.

## Operation
- **Attempt store:** each channel holds a MAX_DLY-bit age vector `pend`. Bit j set means an attempt started j+1 edges ago.
- **Per-edge sequence for each channel:**
  - Compute `win` = `pend` masked to bits [MIN_DLY-1 : MAX_DLY-1].
  - If `b_i`=1, the set of matching attempts is `m` = `win`; otherwise `m` = 0.
  - Every bit of `m` is one evaluation, judged by the sampled `c_i`: a pass if `c_i`=1, a fail if `c_i`=0.
  - In FIRST_MATCH=1, matched bits are cleared before shifting. In FIRST_MATCH=0, they are kept.
  - Shift `pend` up by one, inserting `a_i` at bit 0.
  - Bit MAX_DLY-1 shifts out. An attempt that leaves without matching is vacuous and produces no pulse and no count.
- **Overlap:** any number of attempts may be live at once. One `b` can match several attempts in the same cycle.
- **Counters:** each counter increments by popcount(`m`) on its pass or fail edge and saturates at 2^CNT_W−1. `pass_o`/`fail_o` is a single pulse per cycle, regardless of how many attempts matched.
- **`clear_i`:**
  - Zeroes `pend`, the counters and the pulses on the next edge.
  - Inputs sampled on that same edge are discarded: no new attempt starts and no evaluation occurs.
- **Reset:** `rst_n` low asynchronously clears every `pend`, forces all outputs to 0 and drops in-flight attempts. After release, evaluation restarts from an empty store.
- **Channel independence:** channels share only `clk`, `rst_n` and `clear_i`.

## Timing
- All inputs are sampled at the rising edge of `clk`, following SVA sampled-value semantics.
- Given `a` sampled at edge k and `b`/`c` sampled at edge k+d, with MIN_DLY ≤ d ≤ MAX_DLY:
  - `pass_o` or `fail_o` is high for the cycle after edge k+d.
  - The matching counter holds its updated value from edge k+d onward.
  - Latency from the `b` sample is therefore 1 cycle.
- d < MIN_DLY or d > MAX_DLY: no evaluation.
- Simultaneous `a` and `b` on one edge: the `b` evaluates only older attempts. The new attempt cannot match on its own start edge, since MIN_DLY ≥ 1.
- Reset values: `pass_o`=0, `fail_o`=0, all counters 0, all `pend`=0.
- Saturated counters hold their value. Pulses still fire.

## Structure
- Shared package `range_seq_pkg` holds:
  - the parameter legality checks, as elaboration-time `$error`;
  - the `popcount` function;
  - the `sat_add` function.
- Sub-module `range_seq_chan` holds one channel: the `pend` vector, the match logic and the two counters. It is instantiated NCHAN times in a generate loop.
- The top level only slices and packs the channel buses.

## Test plan
All scenarios use defaults (MIN=1, MAX=3, FIRST_MATCH=1) unless stated.
1. Ch0: a=1 at cycle 5, b=1 at 7, c=0 → `fail_o[0]` high in cycle 8; fail_cnt[0]=1; pass_cnt[0]=0; ch1–3 remain 0.
2. a at 5, b at 9 (d=4), c=0 → no pulse; both counters stay 0. Repeat with b at 6 and c=1 → `pass_o[0]` high in cycle 7; pass_cnt=1.
3. Overlap: a at 5 and 6, b at 7, c=0 → one `fail_o` pulse in cycle 8; fail_cnt=2.
4. Mode: a at 5; b at 6, 7 and 8; c=0.
   - FIRST_MATCH=1 → fail_cnt=1.
   - FIRST_MATCH=0 → fail_cnt=3, with `fail_o` high in cycles 7, 8 and 9.
5. Reset mid-window: a at 5, `rst_n` low during cycle 6 (asynchronous, between edges), b at 7 with c=0 → no pulse; counters 0. `clear_i` at edge 6 gives the same result.
6. Saturation: CNT_W=2, four separate fail scenarios on ch2 → fail_cnt[2]=3 and holds; the fourth `fail_o` pulse still fires.

Source files
------------

// File: rtl/range_seq_pkg.sv
// Shared definitions for the range sequence monitor: parameter legality,
// window mask construction, popcount and saturating add.
package range_seq_pkg;

    localparam int MAX_DLY_LIMIT = 32;
    localparam int CNT_W_LIMIT   = 32;

    // Legal configuration: 1 <= MIN_DLY <= MAX_DLY <= 32, 1 <= CNT_W <= 32.
    // The top level turns a false result into an elaboration-time $error.
    function automatic bit params_ok(input int min_dly, input int max_dly,
                                     input int cnt_w);
        return (min_dly >= 1) && (max_dly >= min_dly) &&
               (max_dly <= MAX_DLY_LIMIT) &&
               (cnt_w >= 1) && (cnt_w <= CNT_W_LIMIT);
    endfunction

    // Age bits [min_dly-1 : max_dly-1] are the attempts inside the delay window.
    function automatic logic [31:0] window_mask(input int min_dly, input int max_dly);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 32; j++) begin
            if ((j >= min_dly - 1) && (j <= max_dly - 1)) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int j = 0; j < 32; j++) begin
            n = n + 6'(v[j]);
        end
        return n;
    endfunction

    // Adds inc to cur and clamps at 2^cnt_w-1; the caller truncates to cnt_w.
    function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input int cnt_w);
        logic [32:0] sum;
        logic [31:0] max_val;
        max_val = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        sum     = {1'b0, cur} + {1'b0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/range_seq_chan.sv
// One monitor channel for (a ##[MIN_DLY:MAX_DLY] b) |-> c: attempt age
// vector, window match, pass/fail pulses and saturating counters.
module range_seq_chan
    import range_seq_pkg::*;
#(
    parameter int MIN_DLY     = 1,
    parameter int MAX_DLY     = 3,
    parameter int FIRST_MATCH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam logic [31:0]        WIN_MASK_FULL = window_mask(MIN_DLY, MAX_DLY);
    localparam logic [MAX_DLY-1:0] WIN_MASK      = WIN_MASK_FULL[MAX_DLY-1:0];

    // Bit j of pend: an attempt started j+1 edges ago and is still live.
    logic [MAX_DLY-1:0] pend;
    logic [MAX_DLY-1:0] pend_nxt;
    logic [MAX_DLY-1:0] match;
    logic [MAX_DLY-1:0] kept;
    logic [5:0]         n_match;
    logic               any_match;
    logic               pass_nxt;
    logic               fail_nxt;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   pass_cnt_nxt;
    logic [CNT_W-1:0]   fail_cnt_nxt;

    // Match in-window attempts against b, retire them if first-match, then age the store.
    // The new attempt from a_i enters at bit 0 after matching, so it never
    // matches on its own start edge.
    always_comb begin
        match     = b_i ? (pend & WIN_MASK) : '0;
        kept      = (FIRST_MATCH != 0) ? (pend & ~match) : pend;
        pend_nxt  = kept << 1;
        pend_nxt[0] = a_i;
        n_match   = popcount(32'(match));
        any_match = |match;
        pass_nxt  = any_match & c_i;
        fail_nxt  = any_match & ~c_i;
        pass_cnt_nxt = pass_cnt;
        fail_cnt_nxt = fail_cnt;
        if (pass_nxt) begin
            pass_cnt_nxt = CNT_W'(sat_add(32'(pass_cnt), 32'(n_match), CNT_W));
        end
        if (fail_nxt) begin
            fail_cnt_nxt = CNT_W'(sat_add(32'(fail_cnt), 32'(n_match), CNT_W));
        end
    end

    // State update; clear discards the inputs sampled on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pass_o   <= 1'b0;
            fail_o   <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear_i) begin
            pend     <= '0;
            pass_o   <= 1'b0;
            fail_o   <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pass_o   <= pass_nxt;
            fail_o   <= fail_nxt;
            pass_cnt <= pass_cnt_nxt;
            fail_cnt <= fail_cnt_nxt;
        end
    end

    assign pass_cnt_o = pass_cnt;
    assign fail_cnt_o = fail_cnt;

endmodule

// File: rtl/range_seq_monitor.sv
// Multi-channel monitor for (a ##[MIN_DLY:MAX_DLY] b) |-> c. The top only
// checks parameters and slices/packs the per-channel buses.
module range_seq_monitor
    import range_seq_pkg::*;
#(
    parameter int NCHAN       = 4,
    parameter int MIN_DLY     = 1,
    parameter int MAX_DLY     = 3,
    parameter int FIRST_MATCH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic [NCHAN-1:0]       a_i,
    input  logic [NCHAN-1:0]       b_i,
    input  logic [NCHAN-1:0]       c_i,
    output logic [NCHAN-1:0]       pass_o,
    output logic [NCHAN-1:0]       fail_o,
    output logic [NCHAN*CNT_W-1:0] pass_cnt_o,
    output logic [NCHAN*CNT_W-1:0] fail_cnt_o
);

    if (!params_ok(MIN_DLY, MAX_DLY, CNT_W)) begin : g_param_check
        $error("range_seq_monitor: illegal MIN_DLY=%0d MAX_DLY=%0d CNT_W=%0d",
               MIN_DLY, MAX_DLY, CNT_W);
    end

    if (NCHAN < 1) begin : g_nchan_check
        $error("range_seq_monitor: NCHAN must be at least 1");
    end

    // One independent channel per bit of a/b/c.
    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        range_seq_chan #(
            .MIN_DLY     (MIN_DLY),
            .MAX_DLY     (MAX_DLY),
            .FIRST_MATCH (FIRST_MATCH),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (clear_i),
            .a_i        (a_i[k]),
            .b_i        (b_i[k]),
            .c_i        (c_i[k]),
            .pass_o     (pass_o[k]),
            .fail_o     (fail_o[k]),
            .pass_cnt_o (pass_cnt_o[k*CNT_W +: CNT_W]),
            .fail_cnt_o (fail_cnt_o[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_range_seq_monitor.sv
// Scoreboard bench for range_seq_monitor. Three instances share stimulus:
// inst 0 defaults, inst 1 FIRST_MATCH=0, inst 2 CNT_W=2. An attempt-list
// model pushes expected outputs per edge; they are popped after the edge.
module tb_range_seq_monitor;

    localparam int MIN_D = 1;
    localparam int MAX_D = 3;
    localparam int NK    = 12;

    typedef struct packed {
        logic [NK-1:0]    pass;
        logic [NK-1:0]    fail;
        logic [NK*16-1:0] pcnt;
        logic [NK*16-1:0] fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic [3:0]  c = '0;

    logic [3:0]  pass0, fail0, pass1, fail1, pass2, fail2;
    logic [63:0] pcnt0, fcnt0, pcnt1, fcnt1;
    logic [7:0]  pcnt2, fcnt2;

    int   starts[NK][$];
    int   pc[NK];
    int   fc[NK];
    int   edge_n = 0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    range_seq_monitor dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b), .c_i(c),
        .pass_o(pass0), .fail_o(fail0), .pass_cnt_o(pcnt0), .fail_cnt_o(fcnt0)
    );

    range_seq_monitor #(.FIRST_MATCH(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b), .c_i(c),
        .pass_o(pass1), .fail_o(fail1), .pass_cnt_o(pcnt1), .fail_cnt_o(fcnt1)
    );

    range_seq_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b), .c_i(c),
        .pass_o(pass2), .fail_o(fail2), .pass_cnt_o(pcnt2), .fail_cnt_o(fcnt2)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    // k = inst*4 + channel
    function automatic int unsigned obs_pulse(input int k, input bit is_pass);
        int ch;
        ch = k % 4;
        case (k / 4)
            0:       return 32'(is_pass ? pass0[ch] : fail0[ch]);
            1:       return 32'(is_pass ? pass1[ch] : fail1[ch]);
            default: return 32'(is_pass ? pass2[ch] : fail2[ch]);
        endcase
    endfunction

    function automatic int unsigned obs_cnt(input int k, input bit is_pass);
        int ch;
        ch = k % 4;
        case (k / 4)
            0:       return 32'(is_pass ? pcnt0[ch*16 +: 16] : fcnt0[ch*16 +: 16]);
            1:       return 32'(is_pass ? pcnt1[ch*16 +: 16] : fcnt1[ch*16 +: 16]);
            default: return 32'(is_pass ? pcnt2[ch*2 +: 2] : fcnt2[ch*2 +: 2]);
        endcase
    endfunction

    // Reference: each attempt is its start edge; it is judged whenever b
    // arrives d edges later with MIN_D <= d <= MAX_D.
    task automatic model_step(input logic [3:0] aa, input logic [3:0] bb,
                              input logic [3:0] cc, input logic clr);
        exp_t e;
        int   nq[$];
        int   ch, np, nf, d, maxc;
        bit   fm, hit;
        e = '0;
        edge_n++;
        for (int k = 0; k < NK; k++) begin
            ch   = k % 4;
            fm   = ((k / 4) != 1);
            maxc = ((k / 4) == 2) ? 3 : 65535;
            np   = 0;
            nf   = 0;
            if (clr) begin
                starts[k].delete();
                pc[k] = 0;
                fc[k] = 0;
            end else begin
                nq.delete();
                for (int i = 0; i < starts[k].size(); i++) begin
                    d   = edge_n - starts[k][i];
                    hit = bb[ch] && (d >= MIN_D) && (d <= MAX_D);
                    if (hit) begin
                        if (cc[ch]) np++;
                        else nf++;
                    end
                    if (!(hit && fm) && (d < MAX_D)) nq.push_back(starts[k][i]);
                end
                starts[k] = nq;
                if (aa[ch]) starts[k].push_back(edge_n);
                pc[k] = (pc[k] + np > maxc) ? maxc : pc[k] + np;
                fc[k] = (fc[k] + nf > maxc) ? maxc : fc[k] + nf;
            end
            e.pass[k] = (np > 0);
            e.fail[k] = (nf > 0);
            e.pcnt[k*16 +: 16] = 16'(pc[k]);
            e.fcnt[k*16 +: 16] = 16'(fc[k]);
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            starts[k].delete();
            pc[k] = 0;
            fc[k] = 0;
        end
    endtask

    // Drive one edge's inputs, then compare every channel after the edge.
    task automatic step(input logic [3:0] aa, input logic [3:0] bb,
                        input logic [3:0] cc, input logic clr);
        exp_t e;
        @(negedge clk);
        a = aa;
        b = bb;
        c = cc;
        clear = clr;
        model_step(aa, bb, cc, clr);
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int k = 0; k < NK; k++) begin
                chk($sformatf("pass_o[k%0d]", k), obs_pulse(k, 1'b1), 32'(e.pass[k]));
                chk($sformatf("fail_o[k%0d]", k), obs_pulse(k, 1'b0), 32'(e.fail[k]));
                chk($sformatf("pass_cnt[k%0d]", k), obs_cnt(k, 1'b1), 32'(e.pcnt[k*16 +: 16]));
                chk($sformatf("fail_cnt[k%0d]", k), obs_cnt(k, 1'b0), 32'(e.fcnt[k*16 +: 16]));
            end
        end
        a = '0;
        b = '0;
        c = '0;
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("%s pass_o[k%0d]", tag, k), obs_pulse(k, 1'b1), 0);
            chk($sformatf("%s fail_o[k%0d]", tag, k), obs_pulse(k, 1'b0), 0);
            chk($sformatf("%s pass_cnt[k%0d]", tag, k), obs_cnt(k, 1'b1), 0);
            chk($sformatf("%s fail_cnt[k%0d]", tag, k), obs_cnt(k, 1'b0), 0);
        end
    endtask

    // Called just after an edge: pull reset low between edges, release before the next.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #16;
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: a, b two edges later, c=0 -> fail on ch0 only
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        chk("s1 fail_o ch0", obs_pulse(0, 1'b0), 1);
        chk("s1 fail_cnt ch0", obs_cnt(0, 1'b0), 1);
        chk("s1 pass_cnt ch0", obs_cnt(0, 1'b1), 0);
        chk("s1 fail_cnt ch1", obs_cnt(1, 1'b0), 0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("s1 fail_o ch0 drops", obs_pulse(0, 1'b0), 0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // 2: d=4 is outside the window; then d=1 with c=1 passes
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        chk("s2 late fail_o", obs_pulse(0, 1'b0), 0);
        chk("s2 late fail_cnt", obs_cnt(0, 1'b0), 0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 4'b0001, 1'b0);
        chk("s2 pass_o", obs_pulse(0, 1'b1), 1);
        chk("s2 pass_cnt", obs_cnt(0, 1'b1), 1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // 3: two overlapping attempts, one b -> one pulse, count 2
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        chk("s3 fail_o", obs_pulse(0, 1'b0), 1);
        chk("s3 fail_cnt", obs_cnt(0, 1'b0), 2);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // 4: one attempt, b on three edges: first-match vs all-match
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b0001, 4'b0000, 1'b0);
            chk($sformatf("s4 fm0 fail_o edge%0d", i), obs_pulse(4, 1'b0), 1);
        end
        chk("s4 fm1 fail_cnt", obs_cnt(0, 1'b0), 1);
        chk("s4 fm0 fail_cnt", obs_cnt(4, 1'b0), 3);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // 5: reset mid-window drops the attempt; clear does likewise
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        async_reset("s5 rst");
        step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        chk("s5 rst fail_o", obs_pulse(0, 1'b0), 0);
        chk("s5 rst fail_cnt", obs_cnt(0, 1'b0), 0);
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        chk("s5 clr fail_o", obs_pulse(0, 1'b0), 0);
        chk("s5 clr fail_cnt", obs_cnt(0, 1'b0), 0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // 6: four fails on ch2; CNT_W=2 saturates at 3, pulse still fires
        for (int i = 0; i < 4; i++) begin
            step(4'b0100, 4'b0000, 4'b0000, 1'b0);
            step(4'b0000, 4'b0100, 4'b0000, 1'b0);
            chk($sformatf("s6 sat fail_o #%0d", i), obs_pulse(10, 1'b0), 1);
        end
        chk("s6 sat fail_cnt", obs_cnt(10, 1'b0), 3);
        chk("s6 wide fail_cnt", obs_cnt(2, 1'b0), 4);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("s6 sat holds", obs_cnt(10, 1'b0), 3);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Random traffic with occasional clears and one mid-run reset.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 39) == 0));
            if (i == 150) async_reset("rand rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
